ysyx_22050710_sram_arbiter: RTL and testbench

Shares the single SRAM-like memory port between the instruction-fetch requester and the memory-stage load/store requester. Sits between the fetch/memory pipeline stages and the memory bus. It selects one request per cycle and tracks outstanding transactions in an in-order ID queue. It routes each `data_ok`/`rdata` response back to the requester that issued it.

---
 rtl/ysyx_22050710_sram_arbiter_pkg.sv | 19 +
 rtl/ysyx_22050710_sram_arbiter_if.sv | 29 ++
 rtl/ysyx_22050710_arb_id_fifo.sv | 65 ++++++
 rtl/ysyx_22050710_sram_arbiter.sv | 131 +++++++++++++
 tb/tb_ysyx_22050710_sram_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22050710_sram_arbiter_pkg.sv
// Shared constants for the SRAM port arbiter: requester IDs and access size codes.
package ysyx_22050710_sram_arbiter_pkg;

    // Requester IDs held in the outstanding-transaction queue
    localparam logic ARB_ID_INST = 1'b0;
    localparam logic ARB_ID_DATA = 1'b1;

    // SRAM-like access size encodings
    localparam logic [2:0] SRAM_SIZE_B = 3'd0;
    localparam logic [2:0] SRAM_SIZE_H = 3'd1;
    localparam logic [2:0] SRAM_SIZE_W = 3'd2;
    localparam logic [2:0] SRAM_SIZE_D = 3'd3;

    // The requester that did not win; used to hand the round-robin turn over
    function automatic logic arb_other(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/ysyx_22050710_sram_arbiter_if.sv
// SRAM-like request/response bus. The master issues commands and receives
// addr_ok/data_ok/rdata; the slave accepts commands and returns responses.
interface ysyx_22050710_sram_arbiter_if #(
    parameter int unsigned ADDR_WD      = 32,
    parameter int unsigned SRAM_DATA_WD = 64
);
    localparam int unsigned STRB_WD = SRAM_DATA_WD / 8;

    logic                    req;
    logic                    wr;
    logic [2:0]              size;
    logic [STRB_WD-1:0]      wstrb;
    logic [ADDR_WD-1:0]      addr;
    logic [SRAM_DATA_WD-1:0] wdata;
    logic                    addr_ok;
    logic                    data_ok;
    logic [SRAM_DATA_WD-1:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/ysyx_22050710_arb_id_fifo.sv
// In-order queue of 1-bit requester IDs for outstanding SRAM transactions.
// Push while full and pop while empty are dropped so the count never wraps.
module ysyx_22050710_arb_id_fifo #(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_push,
    input  logic i_push_id,
    input  logic i_pop,
    output logic o_head_id,
    output logic o_empty,
    output logic o_full
);

    logic [DEPTH-1:0] ids_q, ids_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign o_empty   = (count_q == CNT_W'(0));
    assign o_full    = (count_q == CNT_W'(DEPTH));
    assign o_head_id = ids_q[rd_ptr_q];
    assign push_ok   = i_push && !o_full;
    assign pop_ok    = i_pop && !o_empty;

    // Next-state for storage, power-of-two wrapping pointers and occupancy
    always_comb begin
        ids_d    = ids_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            ids_d[wr_ptr_q] = i_push_id;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue state registers; reset discards every outstanding entry
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ids_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            ids_q    <= ids_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ysyx_22050710_sram_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and the memory
// stage. Requests are granted combinationally; responses come back in order
// and are routed using the ID queue head.
// Build option: YSYX_22050710_ARB_RR_EN selects round-robin arbitration;
// otherwise the memory stage has fixed priority over fetch so the pipeline
// can always drain.
module ysyx_22050710_sram_arbiter
    import ysyx_22050710_sram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WD      = 32,
    parameter int unsigned SRAM_DATA_WD = 64,
    parameter int unsigned OT_DEPTH     = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    ysyx_22050710_sram_arbiter_if.slave   inst_if,
    ysyx_22050710_sram_arbiter_if.slave   data_if,
    ysyx_22050710_sram_arbiter_if.master  mem_if,
    output logic                          o_err
);

    localparam int unsigned STRB_WD = SRAM_DATA_WD / 8;

    logic                    fifo_full, fifo_empty, head_id;
    logic                    can_issue, any_req, fire, resp_valid;
    logic                    grant_id;
    logic                    err_q, err_d;
    logic                    cmd_wr;
    logic [2:0]              cmd_size;
    logic [STRB_WD-1:0]      cmd_wstrb;
    logic [ADDR_WD-1:0]      cmd_addr;
    logic [SRAM_DATA_WD-1:0] cmd_wdata;

    // A slot freed by this cycle's pop only becomes usable next cycle
    assign can_issue = !fifo_full;
    assign any_req   = inst_if.req || data_if.req;
    assign fire      = can_issue && any_req && mem_if.addr_ok;

`ifdef YSYX_22050710_ARB_RR_EN
    logic rr_q, rr_d;

    // Round-robin grant: contested cycles go to the requester whose turn it is
    always_comb begin
        grant_id = ARB_ID_INST;
        if (inst_if.req && data_if.req) begin
            grant_id = rr_q;
        end else if (data_if.req) begin
            grant_id = ARB_ID_DATA;
        end
        rr_d = fire ? arb_other(grant_id) : rr_q;
    end

    // Turn pointer; starts in favour of fetch
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_q <= ARB_ID_INST;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    // Fixed priority: the memory stage always beats fetch
    always_comb begin
        grant_id = ARB_ID_INST;
        if (data_if.req) begin
            grant_id = ARB_ID_DATA;
        end
    end
`endif

    // Command mux: the winner's fields drive the memory port
    always_comb begin
        cmd_wr    = inst_if.wr;
        cmd_size  = inst_if.size;
        cmd_wstrb = inst_if.wstrb;
        cmd_addr  = inst_if.addr;
        cmd_wdata = inst_if.wdata;
        if (grant_id == ARB_ID_DATA) begin
            cmd_wr    = data_if.wr;
            cmd_size  = data_if.size;
            cmd_wstrb = data_if.wstrb;
            cmd_addr  = data_if.addr;
            cmd_wdata = data_if.wdata;
        end
    end

    assign mem_if.req   = can_issue && any_req;
    assign mem_if.wr    = cmd_wr;
    assign mem_if.size  = cmd_size;
    assign mem_if.wstrb = cmd_wstrb;
    assign mem_if.addr  = cmd_addr;
    assign mem_if.wdata = cmd_wdata;

    assign inst_if.addr_ok = fire && (grant_id == ARB_ID_INST);
    assign data_if.addr_ok = fire && (grant_id == ARB_ID_DATA);

    // Response routing from the queue head; a response with nothing outstanding is dropped
    assign resp_valid      = mem_if.data_ok && !fifo_empty;
    assign inst_if.data_ok = resp_valid && (head_id == ARB_ID_INST);
    assign data_if.data_ok = resp_valid && (head_id == ARB_ID_DATA);
    assign inst_if.rdata   = mem_if.rdata;
    assign data_if.rdata   = mem_if.rdata;

    // Spurious-response flag stays set until reset
    assign err_d = err_q || (mem_if.data_ok && fifo_empty);

    // Error flag register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;

    ysyx_22050710_arb_id_fifo #(
        .DEPTH (OT_DEPTH)
    ) u_id_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_push    (fire),
        .i_push_id (grant_id),
        .i_pop     (resp_valid),
        .o_head_id (head_id),
        .o_empty   (fifo_empty),
        .o_full    (fifo_full)
    );

endmodule

// File: tb/tb_ysyx_22050710_sram_arbiter.sv
// Self-checking bench for the SRAM port arbiter. Expected requester IDs are
// queued as requests are driven and popped as responses come back.
module tb_ysyx_22050710_sram_arbiter;
    import ysyx_22050710_sram_arbiter_pkg::*;

    localparam logic [31:0] INST_ADDR = 32'h8000_0000;
    localparam logic [31:0] DATA_ADDR = 32'h1000_0200;

    logic clk;
    logic rst_n;
    logic err;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];
    logic m_rr;

    ysyx_22050710_sram_arbiter_if #(.ADDR_WD(32), .SRAM_DATA_WD(64)) inst_if ();
    ysyx_22050710_sram_arbiter_if #(.ADDR_WD(32), .SRAM_DATA_WD(64)) data_if ();
    ysyx_22050710_sram_arbiter_if #(.ADDR_WD(32), .SRAM_DATA_WD(64)) mem_if ();

    ysyx_22050710_sram_arbiter #(
        .ADDR_WD      (32),
        .SRAM_DATA_WD (64),
        .OT_DEPTH     (2)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .inst_if (inst_if),
        .data_if (data_if),
        .mem_if  (mem_if),
        .o_err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference grant decision
    function automatic logic exp_winner(input logic ir, input logic dr);
`ifdef YSYX_22050710_ARB_RR_EN
        if (ir && dr) return m_rr;
        return dr ? ARB_ID_DATA : ARB_ID_INST;
`else
        if (ir && !dr) return ARB_ID_INST;
        return dr ? ARB_ID_DATA : ARB_ID_INST;
`endif
    endfunction

    task automatic note_fire(input logic id);
        exp_q.push_back(id);
        m_rr = ~id;
    endtask

    task automatic drive(input logic ir, input logic dr, input logic aok,
                         input logic dok, input logic [63:0] rd);
        inst_if.req    = ir;
        data_if.req    = dr;
        mem_if.addr_ok = aok;
        mem_if.data_ok = dok;
        mem_if.rdata   = rd;
        #1;
    endtask

    task automatic apply_reset;
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        m_rr = ARB_ID_INST;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        checks++;
        if (mem_if.req !== 1'b0 || err !== 1'b0 || dut.u_id_fifo.count_q !== 2'd0) begin
            errors++;
            $display("FAIL reset_state req=%b err=%b count=%0d want 0 0 0",
                     mem_if.req, err, dut.u_id_fifo.count_q);
        end
        checks++;
        if ({inst_if.addr_ok, data_if.addr_ok, inst_if.data_ok, data_if.data_ok} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_handshake got %b want 0000",
                     {inst_if.addr_ok, data_if.addr_ok, inst_if.data_ok, data_if.data_ok});
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_rr = ARB_ID_INST;
    endtask

    task automatic test_single_inst;
        logic id;
        apply_reset();
        inst_if.addr = INST_ADDR;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
        checks++;
        if (mem_if.req !== 1'b1 || mem_if.addr !== INST_ADDR || mem_if.wr !== 1'b0) begin
            errors++;
            $display("FAIL single_cmd req=%b addr=%h wr=%b want 1 %h 0",
                     mem_if.req, mem_if.addr, mem_if.wr, INST_ADDR);
        end
        checks++;
        if (inst_if.addr_ok !== 1'b1 || data_if.addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL single_addr_ok inst=%b data=%b want 1 0", inst_if.addr_ok, data_if.addr_ok);
        end
        note_fire(exp_winner(1'b1, 1'b0));
        @(negedge clk);
        checks++;
        if (dut.u_id_fifo.count_q !== 2'd1) begin
            errors++;
            $display("FAIL single_count got %0d want 1", dut.u_id_fifo.count_q);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h1234);
        id = exp_q.pop_front();
        checks++;
        if (inst_if.data_ok !== (id == ARB_ID_INST) || data_if.data_ok !== (id == ARB_ID_DATA)) begin
            errors++;
            $display("FAIL single_route inst=%b data=%b want head id %b", inst_if.data_ok, data_if.data_ok, id);
        end
        checks++;
        if (inst_if.rdata !== 64'h1234 || data_if.rdata !== 64'h1234) begin
            errors++;
            $display("FAIL single_rdata inst=%h data=%h want 1234", inst_if.rdata, data_if.rdata);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        checks++;
        if (dut.u_id_fifo.count_q !== 2'd0) begin
            errors++;
            $display("FAIL single_drain_count got %0d want 0", dut.u_id_fifo.count_q);
        end
    endtask

    task automatic test_both_requesting;
        logic w, id;
        apply_reset();
        inst_if.addr = 32'h8000_0100;
        data_if.addr = DATA_ADDR;
        for (int i = 0; i < 5; i++) begin
            drive(i < 4, i < 4, i < 4, i > 0, 64'h100 + 64'(i));
            if (i > 0) begin
                id = exp_q.pop_front();
                checks++;
                if (inst_if.data_ok !== (id == ARB_ID_INST) || data_if.data_ok !== (id == ARB_ID_DATA)
                    || inst_if.rdata !== 64'h100 + 64'(i)) begin
                    errors++;
                    $display("FAIL both_route[%0d] inst=%b data=%b rdata=%h want id %b rdata %h",
                             i, inst_if.data_ok, data_if.data_ok, inst_if.rdata, id, 64'h100 + 64'(i));
                end
            end
            if (i < 4) begin
                w = exp_winner(1'b1, 1'b1);
                checks++;
                if (inst_if.addr_ok !== (w == ARB_ID_INST) || data_if.addr_ok !== (w == ARB_ID_DATA)) begin
                    errors++;
                    $display("FAIL both_grant[%0d] inst=%b data=%b want winner %b",
                             i, inst_if.addr_ok, data_if.addr_ok, w);
                end
                checks++;
                if (mem_if.addr !== (w ? DATA_ADDR : 32'h8000_0100) || mem_if.wr !== w
                    || mem_if.size !== (w ? SRAM_SIZE_D : SRAM_SIZE_W)) begin
                    errors++;
                    $display("FAIL both_mux[%0d] addr=%h wr=%b size=%0d want winner %b",
                             i, mem_if.addr, mem_if.wr, mem_if.size, w);
                end
                note_fire(w);
            end
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        checks++;
        if (dut.u_id_fifo.count_q !== 2'd0) begin
            errors++;
            $display("FAIL both_count got %0d want 0", dut.u_id_fifo.count_q);
        end
    endtask

    task automatic test_backpressure;
        logic id;
        apply_reset();
        inst_if.addr = INST_ADDR;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
        note_fire(exp_winner(1'b1, 1'b0));
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        checks++;
        if (data_if.addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL bp_second_grant got %b want 1", data_if.addr_ok);
        end
        note_fire(exp_winner(1'b0, 1'b1));
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, k > 0, 1'b1, 1'b0, 64'h0);
            checks++;
            if (mem_if.req !== 1'b0 || inst_if.addr_ok !== 1'b0 || data_if.addr_ok !== 1'b0
                || dut.u_id_fifo.count_q !== 2'd2) begin
                errors++;
                $display("FAIL bp_stall[%0d] req=%b iaok=%b daok=%b count=%0d want 0 0 0 2",
                         k, mem_if.req, inst_if.addr_ok, data_if.addr_ok, dut.u_id_fifo.count_q);
            end
            @(negedge clk);
        end
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 64'hA0 + 64'(k));
            id = exp_q.pop_front();
            checks++;
            if (inst_if.data_ok !== (id == ARB_ID_INST) || data_if.data_ok !== (id == ARB_ID_DATA)
                || data_if.rdata !== 64'hA0 + 64'(k)) begin
                errors++;
                $display("FAIL bp_route[%0d] inst=%b data=%b rdata=%h want id %b",
                         k, inst_if.data_ok, data_if.data_ok, data_if.rdata, id);
            end
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic test_full_overlap;
        logic id;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
        note_fire(exp_winner(1'b1, 1'b0));
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        note_fire(exp_winner(1'b0, 1'b1));
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 64'hB1);
        checks++;
        if (mem_if.req !== 1'b0 || inst_if.addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL overlap_no_grant req=%b aok=%b want 0 0", mem_if.req, inst_if.addr_ok);
        end
        id = exp_q.pop_front();
        checks++;
        if (inst_if.data_ok !== (id == ARB_ID_INST) || data_if.data_ok !== (id == ARB_ID_DATA)) begin
            errors++;
            $display("FAIL overlap_route inst=%b data=%b want id %b", inst_if.data_ok, data_if.data_ok, id);
        end
        @(negedge clk);
        checks++;
        if (dut.u_id_fifo.count_q !== 2'd1) begin
            errors++;
            $display("FAIL overlap_count_mid got %0d want 1", dut.u_id_fifo.count_q);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
        checks++;
        if (inst_if.addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL overlap_regrant got %b want 1", inst_if.addr_ok);
        end
        note_fire(exp_winner(1'b1, 1'b0));
        @(negedge clk);
        checks++;
        if (dut.u_id_fifo.count_q !== 2'd2) begin
            errors++;
            $display("FAIL overlap_count_full got %0d want 2", dut.u_id_fifo.count_q);
        end
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 64'hB2 + 64'(k));
            id = exp_q.pop_front();
            checks++;
            if (inst_if.data_ok !== (id == ARB_ID_INST) || data_if.data_ok !== (id == ARB_ID_DATA)) begin
                errors++;
                $display("FAIL overlap_drain[%0d] inst=%b data=%b want id %b",
                         k, inst_if.data_ok, data_if.data_ok, id);
            end
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic test_spurious;
        logic id;
        apply_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 64'hEE);
        checks++;
        if (inst_if.data_ok !== 1'b0 || data_if.data_ok !== 1'b0) begin
            errors++;
            $display("FAIL spur_route inst=%b data=%b want 0 0", inst_if.data_ok, data_if.data_ok);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        checks++;
        if (err !== 1'b1 || dut.u_id_fifo.count_q !== 2'd0) begin
            errors++;
            $display("FAIL spur_err err=%b count=%0d want 1 0", err, dut.u_id_fifo.count_q);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL spur_sticky got %b want 1", err);
        end
        apply_reset();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL spur_cleared got %b want 0", err);
        end
        inst_if.addr = INST_ADDR;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 64'h0);
        checks++;
        if (inst_if.addr_ok !== 1'b1 || inst_if.data_ok !== 1'b0) begin
            errors++;
            $display("FAIL spur_push aok=%b dok=%b want 1 0", inst_if.addr_ok, inst_if.data_ok);
        end
        note_fire(exp_winner(1'b1, 1'b0));
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        checks++;
        if (err !== 1'b1 || dut.u_id_fifo.count_q !== 2'd1) begin
            errors++;
            $display("FAIL spur_push_state err=%b count=%0d want 1 1", err, dut.u_id_fifo.count_q);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 64'hC1);
        id = exp_q.pop_front();
        checks++;
        if (inst_if.data_ok !== (id == ARB_ID_INST) || inst_if.rdata !== 64'hC1) begin
            errors++;
            $display("FAIL spur_drain dok=%b rdata=%h want id %b rdata c1", inst_if.data_ok, inst_if.rdata, id);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic test_reset_midflight;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
        note_fire(exp_winner(1'b1, 1'b0));
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        note_fire(exp_winner(1'b0, 1'b1));
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
        #2;
        checks++;
        if (dut.u_id_fifo.count_q !== 2'd2 || err !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre count=%0d err=%b want 2 1", dut.u_id_fifo.count_q, err);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut.u_id_fifo.count_q !== 2'd0 || err !== 1'b0 || mem_if.req !== 1'b1) begin
            errors++;
            $display("FAIL midrst_async count=%0d err=%b req=%b want 0 0 1",
                     dut.u_id_fifo.count_q, err, mem_if.req);
        end
        exp_q.delete();
        m_rr = ARB_ID_INST;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        inst_if.req   = 1'b0;
        inst_if.wr    = 1'b0;
        inst_if.size  = SRAM_SIZE_W;
        inst_if.wstrb = 8'h00;
        inst_if.addr  = INST_ADDR;
        inst_if.wdata = 64'h0;
        data_if.req   = 1'b0;
        data_if.wr    = 1'b1;
        data_if.size  = SRAM_SIZE_D;
        data_if.wstrb = 8'hFF;
        data_if.addr  = DATA_ADDR;
        data_if.wdata = 64'hDEAD_BEEF_0000_0001;
        m_rr          = ARB_ID_INST;

        test_reset();
        test_single_inst();
        test_both_requesting();
        test_backpressure();
        test_full_overlap();
        test_spurious();
        test_reset_midflight();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
